// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide over XLEN cycles.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; divides remain iterative either way.
module mdu_iter #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN+1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_alu_data,
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_DIV = 3'b100, OP_REM  = 3'b110;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;

  // Operand decode at accept
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;

  assign is_div   = i_op[2];
  assign a_sgn    = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign b_sgn    = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign a_neg    = a_sgn & i_operand_a[XLEN-1];
  assign b_neg    = b_sgn & i_operand_b[XLEN-1];
  assign a_abs    = a_neg ? -i_operand_a : i_operand_a;
  assign b_abs    = b_neg ? -i_operand_b : i_operand_b;
  assign div_zero = is_div && (i_operand_b == '0);
  assign div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_operand_b == '1);

  always_comb begin
    spec_res = '0;
    if (div_zero)     spec_res = i_op[1] ? i_operand_a : '1;
    else if (div_ovf) spec_res = i_op[1] ? '0 : i_operand_a;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
  logic [XLEN-1:0]   fm_res;
  // Sign-extended 2*XLEN multiply yields the exact signed/unsigned product modulo 2^(2*XLEN)
  assign fm_a    = {{XLEN{a_neg}}, i_operand_a};
  assign fm_b    = {{XLEN{b_neg}}, i_operand_b};
  assign fm_prod = fm_a * fm_b;
  assign fm_res  = (i_op == OP_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
`endif

  // One radix-2 step; {hi,lo} holds partial product, or remainder:quotient
  logic [XLEN:0]     msum, dshl, dtrial;
  logic              dok;
  logic [XLEN-1:0]   it_hi, it_lo, mhi, mlo, dhi, dlo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   fin_res;

  assign msum   = {1'b0, hi_q} + ({1'b0, b_q} & {(XLEN+1){lo_q[0]}});
  assign mhi    = msum[XLEN:1];
  assign mlo    = {msum[0], lo_q[XLEN-1:1]};
  assign dshl   = {hi_q, lo_q[XLEN-1]};
  assign dtrial = dshl - {1'b0, b_q};
  assign dok    = ~dtrial[XLEN];
  assign dhi    = dok ? dtrial[XLEN-1:0] : dshl[XLEN-1:0];
  assign dlo    = {lo_q[XLEN-2:0], dok};
  assign it_hi  = op_q[2] ? dhi : mhi;
  assign it_lo  = op_q[2] ? dlo : mlo;
  assign prod   = {it_hi, it_lo};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    fin_res = '0;
    case (op_q)
      OP_MUL:                 fin_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = neg_q ? -it_lo : it_lo;
      default:                fin_res = neg_q ? -it_hi : it_hi;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_kill) begin
          op_d  = i_op;
          // Remainder follows the dividend; product and quotient follow the XOR of signs
          neg_d = (is_div && i_op[1]) ? a_neg : (a_neg ^ b_neg);
          hi_d  = '0;
          lo_d  = a_abs;
          b_d   = b_abs;
          cnt_d = CNT_W'(XLEN);
          if (div_zero || div_ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!is_div) begin
            res_d   = fm_res;
            state_d = S_DONE;
          end
`endif
          else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (i_kill) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = it_hi;
          lo_d  = it_lo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            res_d   = fin_res;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_kill || i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_valid    = (state_q == S_DONE);
  assign o_busy     = (state_q != S_IDLE);
  assign o_alu_data = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: results, latency, special cases, backpressure, kill and reset.
module tb_mdu_iter;
  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic            i_clk = 1'b0;
  logic            i_rst, i_valid, i_kill, i_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_operand_a, i_operand_b;
  logic            o_ready, o_valid, o_busy;
  logic [XLEN-1:0] o_alu_data;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_kill(i_kill), .o_valid(o_valid), .i_ready(i_ready),
    .o_alu_data(o_alu_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Issue one op with i_ready high; returns the result and the cycle o_valid first rose (-1 on timeout).
  task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       output logic [XLEN-1:0] d, output int lat);
    @(negedge i_clk);
    i_op = op; i_operand_a = a; i_operand_b = b; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_operand_a = $urandom; i_operand_b = $urandom;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_valid) lat = -1;
    d = o_alu_data;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b0;
    i_op = '0; i_operand_a = '0; i_operand_b = '0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_ready, o_valid, o_busy} !== 3'b100 || o_alu_data !== '0) begin
      errors++;
      $display("FAIL reset: rdy/vld/busy=%b data=%h expected 100 / 0", {o_ready, o_valid, o_busy}, o_alu_data);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_mul_timing();
    int first_v, v_cnt, rdy_bad, c;
    @(negedge i_clk);
    i_op = MUL; i_operand_a = 32'd7; i_operand_b = 32'hFFFF_FFFD; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_operand_a = 32'h1234_5678; i_operand_b = 32'h9ABC_DEF0;
    first_v = -1; v_cnt = 0; rdy_bad = 0;
    for (c = 1; c <= 40; c++) begin
      if (o_valid) begin
        v_cnt++;
        if (first_v < 0) begin
          first_v = c;
          checks++;
          if (o_alu_data !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_data: got %h expected FFFFFFEB", o_alu_data);
          end
        end
      end
      if (c <= MUL_LAT && o_ready) rdy_bad++;
      if (c == MUL_LAT + 1) begin
        checks++;
        if (o_ready !== 1'b1) begin
          errors++;
          $display("FAIL mul_ready_after: got %b expected 1", o_ready);
        end
      end
      @(negedge i_clk);
    end
    checks++;
    if (first_v != MUL_LAT || v_cnt != 1) begin
      errors++;
      $display("FAIL mul_latency: first=%0d count=%0d expected %0d / 1", first_v, v_cnt, MUL_LAT);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL mul_ready_low: ready high in %0d busy cycles, expected 0", rdy_bad);
    end
  endtask

  task automatic test_mulh();
    logic [XLEN-1:0] d;
    int lat;
    do_op(MULH, 32'h8000_0000, 32'h8000_0000, d, lat);
    checks++;
    if (d !== 32'h4000_0000 || lat != MUL_LAT) begin
      errors++; $display("FAIL mulh: got %h lat %0d expected 40000000 lat %0d", d, lat, MUL_LAT);
    end
    do_op(MULHSU, 32'h8000_0000, 32'h8000_0000, d, lat);
    checks++;
    if (d !== 32'hC000_0000 || lat != MUL_LAT) begin
      errors++; $display("FAIL mulhsu: got %h lat %0d expected C0000000 lat %0d", d, lat, MUL_LAT);
    end
    do_op(MULHU, 32'h8000_0000, 32'h8000_0000, d, lat);
    checks++;
    if (d !== 32'h4000_0000 || lat != MUL_LAT) begin
      errors++; $display("FAIL mulhu: got %h lat %0d expected 40000000 lat %0d", d, lat, MUL_LAT);
    end
    do_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mulhu_max: got %h expected FFFFFFFE", d);
    end
    do_op(MUL, 32'h0001_0003, 32'h0002_0005, d, lat);
    checks++;
    if (d !== 32'h000B_000F) begin
      errors++; $display("FAIL mul_low: got %h expected 000B000F", d);
    end
  endtask

  task automatic test_div_special();
    logic [XLEN-1:0] d;
    int lat;
    do_op(DIV, 32'd100, 32'd0, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF || lat != 1) begin
      errors++; $display("FAIL div_zero: got %h lat %0d expected FFFFFFFF lat 1", d, lat);
    end
    do_op(REMU, 32'd100, 32'd0, d, lat);
    checks++;
    if (d !== 32'd100 || lat != 1) begin
      errors++; $display("FAIL remu_zero: got %h lat %0d expected 00000064 lat 1", d, lat);
    end
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, d, lat);
    checks++;
    if (d !== 32'h8000_0000 || lat != 1) begin
      errors++; $display("FAIL div_ovf: got %h lat %0d expected 80000000 lat 1", d, lat);
    end
    do_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, d, lat);
    checks++;
    if (d !== 32'h0 || lat != 1) begin
      errors++; $display("FAIL rem_ovf: got %h lat %0d expected 0 lat 1", d, lat);
    end
  endtask

  task automatic test_div_signed();
    logic [XLEN-1:0] d;
    int lat;
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFD || lat != DIV_LAT) begin
      errors++; $display("FAIL div_neg: got %h lat %0d expected FFFFFFFD lat %0d", d, lat, DIV_LAT);
    end
    do_op(REM, 32'hFFFF_FFF9, 32'd2, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rem_neg: got %h expected FFFFFFFF", d);
    end
    do_op(REM, 32'd7, 32'hFFFF_FFFE, d, lat);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL rem_negdiv: got %h expected 00000001", d);
    end
    do_op(DIV, 32'd7, 32'hFFFF_FFFE, d, lat);
    checks++;
    if (d !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_negdiv: got %h expected FFFFFFFD", d);
    end
    do_op(REMU, 32'd100, 32'd7, d, lat);
    checks++;
    if (d !== 32'd2) begin
      errors++; $display("FAIL remu: got %h expected 00000002", d);
    end
  endtask

  task automatic test_backpressure();
    int n, bad;
    @(negedge i_clk);
    i_op = DIVU; i_operand_a = 32'd100; i_operand_b = 32'd7; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_operand_a = 32'hDEAD_BEEF; i_operand_b = 32'h1;
    n = 1;
    while (!o_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (n != DIV_LAT || !o_valid) begin
      errors++; $display("FAIL bp_latency: got %0d expected %0d", n, DIV_LAT);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_alu_data !== 32'd14 || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
      @(negedge i_clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d bad cycles, expected 0 (data 14, ready 0, valid 1)", bad);
    end
    // Request presented together with i_ready; DONE->IDLE first, then accept.
    i_ready = 1'b1; i_valid = 1'b1; i_op = MUL; i_operand_a = 32'd3; i_operand_b = 32'd5;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL bp_next_accept: ready=%b busy=%b expected 0 1", o_ready, o_busy);
    end
    n = 1;
    while (!o_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_alu_data !== 32'd15 || n != MUL_LAT) begin
      errors++; $display("FAIL bp_next_data: got %h lat %0d expected 0000000F lat %0d", o_alu_data, n, MUL_LAT);
    end
    @(negedge i_clk);
  endtask

  task automatic test_kill();
    int vcnt;
    @(negedge i_clk);
    i_op = DIV; i_operand_a = 32'd100; i_operand_b = 32'd7; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL kill_busy: ready/valid/busy=%b%b%b expected 100", o_ready, o_valid, o_busy);
    end
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) vcnt++;
      @(negedge i_clk);
    end
    checks++;
    if (vcnt != 0) begin
      errors++; $display("FAIL kill_no_result: valid seen %0d cycles expected 0", vcnt);
    end
    i_op = DIVU; i_valid = 1'b1; i_kill = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; i_kill = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL kill_blocks_accept: ready=%b busy=%b expected 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    logic [XLEN-1:0] d;
    int lat;
    @(negedge i_clk);
    i_op = DIV; i_operand_a = 32'd100; i_operand_b = 32'd7; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_ready, o_valid, o_busy} !== 3'b100 || o_alu_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: rdy/vld/busy=%b data=%h expected 100 / 0", {o_ready, o_valid, o_busy}, o_alu_data);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) vcnt++;
      @(negedge i_clk);
    end
    checks++;
    if (vcnt != 0) begin
      errors++; $display("FAIL reset_no_result: valid seen %0d cycles expected 0", vcnt);
    end
    do_op(DIVU, 32'd100, 32'd7, d, lat);
    checks++;
    if (d !== 32'd14 || lat != DIV_LAT) begin
      errors++; $display("FAIL after_reset_divu: got %h lat %0d expected 0000000E lat %0d", d, lat, DIV_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mulh();
    test_div_special();
    test_div_signed();
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative, parametrised multiply/divide unit that extends the execute stage's single-cycle integer ALU with the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and computes it with a radix-2 shift-add or shift-subtract datapath over XLEN cycles. The result is held on a valid/ready output until the pipeline takes it, and a kill input lets a flush abandon an in-flight operation.

## Interface
- XLEN, 32: operand and result width, even, ≥ 4.
- CNT_W, $clog2(XLEN+1): width of the iteration counter (derived).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_valid  in  1  operation request.
- o_ready  out  1  unit can accept; high only in IDLE.
- i_op  in  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_operand_a  in  XLEN  rs1, the multiplicand or dividend.
- i_operand_b  in  XLEN  rs2, the multiplier or divisor.
- i_kill  in  1  abort any in-flight operation (pipeline flush).
- o_valid  out  1  o_alu_data holds a result.
- i_ready  in  1  consumer takes the result.
- o_alu_data  out  XLEN  result.
- o_busy  out  1  high in BUSY or DONE.

## Operation
- Reset values (immediate, asynchronous):
  - state = IDLE
  - o_ready = 1
  - o_valid = 0
  - o_busy = 0
  - o_alu_data = 0
  - counter = 0
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - Accept occurs when i_valid & o_ready & !i_kill.
  - On accept, the unit latches i_op and both operands, takes absolute values per signedness, and loads counter = XLEN.
  - It then goes to BUSY, or goes straight to DONE on a divide special case.
- Signedness of each operand:
  - MULH, DIV and REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - All other operations: both unsigned.
- BUSY: one radix-2 iteration per cycle and counter decrements. When counter reaches 1, the next edge:
  - applies sign correction (negate the 2·XLEN product, quotient or remainder as required);
  - registers the result into o_alu_data;
  - moves to DONE.
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2·XLEN-1:XLEN].
  - REM: the remainder takes the dividend's sign.
- DONE:
  - o_valid = 1 and o_alu_data is stable.
  - On i_ready the next state is IDLE and o_valid falls.
  - With i_ready low, the unit stays in DONE indefinitely.
- Divide special cases resolve at accept, with no iterations:
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (a = 2^(XLEN-1) negative, b = −1): DIV gives the dividend; REM gives 0.
- i_kill:
  - In BUSY or DONE, the next state is IDLE with o_valid = 0 and the result discarded.
  - i_kill beats i_ready in the same cycle.
  - In IDLE, i_kill blocks acceptance.
- Operand inputs are sampled only at accept; later changes are ignored.

## Timing
- Accept edge is cycle 0.
- Normal operation: o_valid first high in cycle XLEN+1, i.e. cycle 33 for XLEN = 32.
- Divide special case: o_valid high in cycle 1.
- Back-to-back: the DONE → IDLE edge is taken on i_ready. The next accept is possible the cycle after, so the minimum issue interval is XLEN+2 cycles.
- o_ready = (state == IDLE), a registered decode with no combinational path from i_valid.
- o_valid is a registered decode; o_alu_data changes only on the edge entering DONE.
- Reset asserted mid-operation: all outputs return to reset values immediately; no result is produced.

## Configuration
- MDU_FAST_MUL_EN:
  - Defined: MUL, MULH, MULHSU and MULHU use a single-cycle 2·XLEN combinational multiplier. The accept edge goes straight to DONE and o_valid is high in cycle 1. Divide operations stay iterative.
  - Undefined: all multiplies use the iterative path with XLEN+1 cycle latency.
- Results are bit-identical in both builds.

## Test plan
- XLEN = 32, MUL a = 7, b = 0xFFFFFFFD (−3), i_ready held high → o_alu_data = 0xFFFFFFEB. o_valid is high in exactly cycle 33 (cycle 1 with MDU_FAST_MUL_EN). o_ready is low in cycles 1–33.
- MULH, MULHSU and MULHU with a = b = 0x80000000 → 0x40000000, 0xC0000000 and 0x40000000 respectively.
- Divisor zero:
  - DIV 0x00000064 / 0 → 0xFFFFFFFF.
  - REMU 0x00000064 / 0 → 0x00000064.
  - o_valid in cycle 1 for both.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. Signed case: DIV −7 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- Backpressure: DIVU 100 / 7 with i_ready low 5 cycles after o_valid rises → o_alu_data stays 14 and o_ready stays low. After i_ready, the next request is accepted one cycle later.
- Kill and reset:
  - i_kill in cycle 10 of a DIV → o_valid never rises and o_ready = 1 in cycle 11.
  - i_rst pulsed mid-BUSY → outputs go to reset values before the next clock edge.
